// File: rtl/rf_scoreboard_if.sv
// rf_sb_if: decode/writeback side bundle for rf_scoreboard.
//   slave  : scoreboard view (issue/retire/control in, hazard/status out)
//   master : decode/writeback driver view
interface rf_sb_if #(
  parameter int NREG = 8,
  parameter int AW   = 3
);
  logic            issue_valid;
  logic            issue_wr;
  logic [AW-1:0]   issue_rdst;
  logic            use_src1;
  logic [AW-1:0]   issue_rsrc1;
  logic            use_src2;
  logic [AW-1:0]   issue_rsrc2;
  logic            wb_valid;
  logic [AW-1:0]   wb_rdst;
  logic            flush;
  logic            drain_req;
  logic            ctrl_haz;
  logic            issue_ack;
  logic            drain_done;
  logic [NREG-1:0] pending;
  logic            sb_err;

  modport slave (
    input  issue_valid, issue_wr, issue_rdst, use_src1, issue_rsrc1,
           use_src2, issue_rsrc2, wb_valid, wb_rdst, flush, drain_req,
    output ctrl_haz, issue_ack, drain_done, pending, sb_err
  );

  modport master (
    output issue_valid, issue_wr, issue_rdst, use_src1, issue_rsrc1,
           use_src2, issue_rsrc2, wb_valid, wb_rdst, flush, drain_req,
    input  ctrl_haz, issue_ack, drain_done, pending, sb_err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: issue/hazard scheduler for the decode-stage register file.
//   Per-register pending-write counters stall decode on RAW hazards and on
//   destination counter saturation; a small FSM drains in-flight writes for
//   control-flow / interrupt entry.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active low
//   sb   - rf_sb_if.slave: issue fields, writeback retire, flush, drain_req in;
//          ctrl_haz, issue_ack, drain_done, pending[NREG], sb_err out
// Build option:
//   RF_SB_BYPASS_EN - a source whose only outstanding write retires this cycle
//                     does not stall (the register file forwards writeData).
module rf_scoreboard #(
  parameter int NREG  = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 2
) (
  input  logic     clk,
  input  logic     rst,
  rf_sb_if.slave   sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [NREG-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]             pend_q, pend_d;
  logic                        err_q, err_d;
  logic                        byp1, byp2;
  logic                        src1_hit, src2_hit, sat, haz, ack;
  logic                        done;

`ifdef RF_SB_BYPASS_EN
  // Last outstanding write to the source retires now: value comes off the
  // writeback bus, so the read need not wait.
  assign byp1 = sb.wb_valid && (sb.wb_rdst == sb.issue_rsrc1) &&
                (cnt_q[sb.issue_rsrc1] == CNT_ONE);
  assign byp2 = sb.wb_valid && (sb.wb_rdst == sb.issue_rsrc2) &&
                (cnt_q[sb.issue_rsrc2] == CNT_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign src1_hit = sb.use_src1 & pend_q[sb.issue_rsrc1] & ~byp1;
  assign src2_hit = sb.use_src2 & pend_q[sb.issue_rsrc2] & ~byp2;
  assign sat      = sb.issue_wr & (cnt_q[sb.issue_rdst] == CNT_MAX);
  assign haz      = sb.issue_valid & (src1_hit | src2_hit | sat | (state_q != IDLE));
  assign ack      = sb.issue_valid & ~haz;

  // Per-register counters: issue and retire in the same cycle cancel out;
  // a retire at zero is ignored here and flagged through err_d.
  for (genvar r = 0; r < NREG; r++) begin : g_cnt
    logic inc, dec;
    assign inc = ack & sb.issue_wr & (sb.issue_rdst == AW'(r));
    assign dec = sb.wb_valid & (sb.wb_rdst == AW'(r)) & (cnt_q[r] != '0);
    assign cnt_d[r] = sb.flush       ? '0 :
                      (inc & ~dec)   ? cnt_q[r] + CNT_ONE :
                      (dec & ~inc)   ? cnt_q[r] - CNT_ONE :
                                       cnt_q[r];
    assign pend_d[r] = |cnt_d[r];
  end

  // Flush discards the retire too, so it cannot raise the error.
  assign err_d = err_q | (~sb.flush & sb.wb_valid & (cnt_q[sb.wb_rdst] == '0));

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (sb.drain_req) state_d = DRAIN;
      // Look at next-state counters so the retiring edge itself completes it.
      DRAIN:   if (cnt_d == '0) state_d = DONE;
      DONE: begin
        done    = ~sb.flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (sb.flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign sb.ctrl_haz   = haz;
  assign sb.issue_ack  = ack;
  assign sb.drain_done = done;
  assign sb.pending    = pend_q;
  assign sb.sb_err     = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Testbench for rf_scoreboard: table of one-cycle vectors with hand-derived
// expected outputs, queued at drive time and compared mid-cycle, plus a
// hand-written asynchronous reset sequence.
module tb_rf_scoreboard;

`ifdef RF_SB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_sb_if #(.NREG(8), .AW(3)) sb();

  rf_scoreboard #(.NREG(8), .AW(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  // exp = {ctrl_haz, issue_ack, drain_done, sb_err, pending[7:0]}
  typedef struct {
    string      name;
    logic       iv, iw;
    logic [2:0] rd;
    logic       u1;
    logic [2:0] s1;
    logic       u2;
    logic [2:0] s2;
    logic       wv;
    logic [2:0] wr;
    logic       fl, dr;
    logic [11:0] exp;
  } vec_t;

  localparam int NV = 46;
  vec_t        tbl [NV];
  logic [11:0] expq [$];
  string       nameq [$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic vec_t mk(string n, logic iv, logic iw, logic [2:0] rd,
                              logic u1, logic [2:0] s1, logic u2, logic [2:0] s2,
                              logic wv, logic [2:0] wr, logic fl, logic dr,
                              logic haz, logic ack, logic done, logic err,
                              logic [7:0] pend);
    vec_t v;
    v.name = n; v.iv = iv; v.iw = iw; v.rd = rd; v.u1 = u1; v.s1 = s1;
    v.u2 = u2; v.s2 = s2; v.wv = wv; v.wr = wr; v.fl = fl; v.dr = dr;
    v.exp = {haz, ack, done, err, pend};
    return v;
  endfunction

  task automatic drive(vec_t v);
    sb.issue_valid = v.iv; sb.issue_wr = v.iw; sb.issue_rdst = v.rd;
    sb.use_src1 = v.u1; sb.issue_rsrc1 = v.s1;
    sb.use_src2 = v.u2; sb.issue_rsrc2 = v.s2;
    sb.wb_valid = v.wv; sb.wb_rdst = v.wr;
    sb.flush = v.fl; sb.drain_req = v.dr;
  endtask

  task automatic compare();
    logic [11:0] e, o;
    string nm;
    e  = expq.pop_front();
    nm = nameq.pop_front();
    o  = {sb.ctrl_haz, sb.issue_ack, sb.drain_done, sb.sb_err, sb.pending};
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL %s: haz/ack/done/err/pend got %b/%b/%b/%b/%h expected %b/%b/%b/%b/%h",
               nm, o[11], o[10], o[9], o[8], o[7:0], e[11], e[10], e[9], e[8], e[7:0]);
    end
  endtask

  task automatic apply(vec_t v);
    @(posedge clk); #1;
    drive(v);
    expq.push_back(v.exp);
    nameq.push_back(v.name);
    @(negedge clk);
    compare();
  endtask

  task automatic expect_now(string nm, logic [11:0] e);
    expq.push_back(e);
    nameq.push_back(nm);
    compare();
  endtask

  vec_t idle;

  initial begin
    //                  name          iv iw rd u1 s1 u2 s2 wv wr fl dr  haz ack dn er pend
    tbl[0]  = mk("idle0",       0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0, 8'h00);
    tbl[1]  = mk("iss_r3",      1,1,3, 0,0, 0,0, 0,0, 0,0,  0,1,0,0, 8'h00);
    tbl[2]  = mk("raw_stall",   1,0,0, 1,3, 0,0, 0,0, 0,0,  1,0,0,0, 8'h08);
    tbl[3]  = mk("raw_stall2",  1,0,0, 1,3, 0,0, 0,0, 0,0,  1,0,0,0, 8'h08);
    tbl[4]  = mk("raw_wb",      1,0,0, 1,3, 0,0, 1,3, 0,0,  ~BYP,BYP,0,0, 8'h08);
    tbl[5]  = mk("raw_go",      1,0,0, 1,3, 0,0, 0,0, 0,0,  0,1,0,0, 8'h00);
    tbl[6]  = mk("sat1",        1,1,5, 0,0, 0,0, 0,0, 0,0,  0,1,0,0, 8'h00);
    tbl[7]  = mk("sat2",        1,1,5, 0,0, 0,0, 0,0, 0,0,  0,1,0,0, 8'h20);
    tbl[8]  = mk("sat3",        1,1,5, 0,0, 0,0, 0,0, 0,0,  0,1,0,0, 8'h20);
    tbl[9]  = mk("sat_full",    1,1,5, 0,0, 0,0, 0,0, 0,0,  1,0,0,0, 8'h20);
    tbl[10] = mk("sat_wb",      1,1,5, 0,0, 0,0, 1,5, 0,0,  1,0,0,0, 8'h20);
    tbl[11] = mk("sat_acc",     1,1,5, 0,0, 0,0, 0,0, 0,0,  0,1,0,0, 8'h20);
    tbl[12] = mk("wb5_a",       0,0,0, 0,0, 0,0, 1,5, 0,0,  0,0,0,0, 8'h20);
    tbl[13] = mk("wb5_b",       0,0,0, 0,0, 0,0, 1,5, 0,0,  0,0,0,0, 8'h20);
    tbl[14] = mk("wb5_c",       0,0,0, 0,0, 0,0, 1,5, 0,0,  0,0,0,0, 8'h20);
    tbl[15] = mk("r5_clear",    0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0, 8'h00);
    tbl[16] = mk("iss_r2",      1,1,2, 0,0, 0,0, 0,0, 0,0,  0,1,0,0, 8'h00);
    tbl[17] = mk("simul",       1,1,2, 0,0, 0,0, 1,2, 0,0,  0,1,0,0, 8'h04);
    tbl[18] = mk("simul_chk",   0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0, 8'h04);
    tbl[19] = mk("wb_r2",       0,0,0, 0,0, 0,0, 1,2, 0,0,  0,0,0,0, 8'h04);
    tbl[20] = mk("iss_r1",      1,1,1, 0,0, 0,0, 0,0, 0,0,  0,1,0,0, 8'h00);
    tbl[21] = mk("iss_r4",      1,1,4, 0,0, 0,0, 0,0, 0,0,  0,1,0,0, 8'h02);
    tbl[22] = mk("drain_req",   0,0,0, 0,0, 0,0, 0,0, 0,1,  0,0,0,0, 8'h12);
    tbl[23] = mk("drain_blk",   1,1,0, 0,0, 0,0, 0,0, 0,0,  1,0,0,0, 8'h12);
    tbl[24] = mk("drain_wb1",   1,1,0, 0,0, 0,0, 1,1, 0,0,  1,0,0,0, 8'h12);
    tbl[25] = mk("drain_wb4",   1,1,0, 0,0, 0,0, 1,4, 0,0,  1,0,0,0, 8'h10);
    tbl[26] = mk("drain_done",  1,1,0, 0,0, 0,0, 0,0, 0,0,  1,0,1,0, 8'h00);
    tbl[27] = mk("post_drain",  0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0, 8'h00);
    tbl[28] = mk("drain_empty", 0,0,0, 0,0, 0,0, 0,0, 0,1,  0,0,0,0, 8'h00);
    tbl[29] = mk("drain_e1",    1,1,0, 0,0, 0,0, 0,0, 0,0,  1,0,0,0, 8'h00);
    tbl[30] = mk("drain_e2",    0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,1,0, 8'h00);
    tbl[31] = mk("drain_e3",    0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0, 8'h00);
    tbl[32] = mk("err_wb",      0,0,0, 0,0, 0,0, 1,6, 0,0,  0,0,0,0, 8'h00);
    tbl[33] = mk("err_sticky",  0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,1, 8'h00);
    tbl[34] = mk("iss_r7",      1,1,7, 0,0, 0,0, 0,0, 0,0,  0,1,0,1, 8'h00);
    tbl[35] = mk("drain7",      0,0,0, 0,0, 0,0, 0,0, 0,1,  0,0,0,1, 8'h80);
    tbl[36] = mk("flush_drain", 1,1,3, 0,0, 0,0, 0,0, 1,0,  1,0,0,1, 8'h80);
    tbl[37] = mk("post_flush",  1,1,7, 0,0, 0,0, 0,0, 0,0,  0,1,0,1, 8'h00);
    tbl[38] = mk("wb7",         0,0,0, 0,0, 0,0, 1,7, 0,0,  0,0,0,1, 8'h80);
    tbl[39] = mk("r7_clear",    0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,1, 8'h00);
    tbl[40] = mk("flush_iss",   1,1,0, 0,0, 0,0, 0,0, 1,0,  0,1,0,1, 8'h00);
    tbl[41] = mk("flush_iss2",  0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,1, 8'h00);
    tbl[42] = mk("iss_r6",      1,1,6, 0,0, 0,0, 0,0, 0,0,  0,1,0,1, 8'h00);
    tbl[43] = mk("raw_src2",    1,0,0, 1,0, 1,6, 0,0, 0,0,  1,0,0,1, 8'h40);
    tbl[44] = mk("wb6",         0,0,0, 0,0, 0,0, 1,6, 0,0,  0,0,0,1, 8'h40);
    tbl[45] = mk("r6_clear",    0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,1, 8'h00);
    idle    = mk("idle",        0,0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0, 8'h00);

    // Power-on reset
    rst = 1'b0;
    drive(idle);
    repeat (2) @(posedge clk);
    #1 expect_now("reset_state", 12'h000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) apply(tbl[i]);

    // Asynchronous reset mid-run with R1 pending and sb_err set
    @(posedge clk); #1;
    drive(mk("r1a", 1,1,1, 0,0, 0,0, 0,0, 0,0, 0,0,0,0, 8'h00));
    @(posedge clk); #1;
    drive(mk("r1b", 1,1,1, 0,0, 0,0, 0,0, 0,0, 0,0,0,0, 8'h00));
    @(posedge clk); #1;
    drive(mk("r1use", 1,0,0, 1,1, 0,0, 0,0, 0,0, 0,0,0,0, 8'h00));
    #1 expect_now("pre_areset", {1'b1, 1'b0, 1'b0, 1'b1, 8'h02});
    rst = 1'b0;
    #1 expect_now("areset_now", {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    drive(idle);
    rst = 1'b1;
    apply(idle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
